// File: rtl/u_rec.sv
// UART receiver: 16x oversampled, start-bit qualified at mid-cell, LSB-first
// shift, with a level-valid/read-strobe host handshake plus framing/overrun status.
module u_rec #(
    parameter int WORD_LEN   = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                uart_recH,
    input  logic                rec_readH,
    output logic [WORD_LEN-1:0] rec_dataH,
    output logic                rec_validH,
    output logic                frame_errH,
    output logic                overrunH,
    output logic                rec_busyH
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(WORD_LEN + 1);

    localparam logic [CNT_W-1:0] CELL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] MID_LAST  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(WORD_LEN - 1);

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_START = 3'd1,
        R_DATA  = 3'd2,
        R_STOP  = 3'd3,
        R_BREAK = 3'd4
    } state_t;

    state_t              state;
    logic                sync_p0;
    logic                sync_p1;
    logic                rx_sync;
    logic [CNT_W-1:0]    cell_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [WORD_LEN-1:0] shift_reg;

    assign rx_sync = sync_p1;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_p0    <= 1'b1;
            sync_p1    <= 1'b1;
            state      <= R_IDLE;
            cell_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            rec_dataH  <= '0;
            rec_validH <= 1'b0;
            frame_errH <= 1'b0;
            overrunH   <= 1'b0;
            rec_busyH  <= 1'b0;
        end else begin
            // Synchronizer stage boundary: line -> sync_p0 -> sync_p1 (rx_sync)
            sync_p0 <= uart_recH;
            sync_p1 <= sync_p0;

            if (rec_readH && rec_validH) begin
                rec_validH <= 1'b0;
                overrunH   <= 1'b0;
            end

            case (state)
                R_IDLE: begin
                    cell_cnt <= '0;
                    if (!rx_sync) begin
                        state     <= R_START;
                        rec_busyH <= 1'b1;
                    end
                end

                R_START: begin
                    if (cell_cnt == MID_LAST) begin
                        cell_cnt <= '0;
                        if (!rx_sync) begin
                            state   <= R_DATA;
                            bit_cnt <= '0;
                        end else begin
                            state     <= R_IDLE;
                            rec_busyH <= 1'b0;
                        end
                    end else begin
                        cell_cnt <= cell_cnt + 1'b1;
                    end
                end

                R_DATA: begin
                    if (cell_cnt == CELL_LAST) begin
                        cell_cnt  <= '0;
                        shift_reg <= {rx_sync, shift_reg[WORD_LEN-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == BITS_LAST) begin
                            state <= R_STOP;
                        end
                    end else begin
                        cell_cnt <= cell_cnt + 1'b1;
                    end
                end

                R_STOP: begin
                    if (cell_cnt == CELL_LAST) begin
                        cell_cnt   <= '0;
                        rec_dataH  <= shift_reg;
                        frame_errH <= ~rx_sync;
                        rec_validH <= 1'b1;
                        // A same-cycle read makes room for the new word, so no overrun.
                        overrunH   <= rec_validH && !rec_readH;
                        if (rx_sync) begin
                            state     <= R_IDLE;
                            rec_busyH <= 1'b0;
                        end else begin
                            state <= R_BREAK;
                        end
                    end else begin
                        cell_cnt <= cell_cnt + 1'b1;
                    end
                end

                R_BREAK: begin
                    cell_cnt <= '0;
                    if (rx_sync) begin
                        state     <= R_IDLE;
                        rec_busyH <= 1'b0;
                    end
                end

                default: begin
                    state     <= R_IDLE;
                    cell_cnt  <= '0;
                    rec_busyH <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_u_rec.sv
// Directed bench for u_rec: expected words go into a queue as frames are sent;
// a negedge monitor pops and compares whenever the DUT presents a new word.
module tb_u_rec;

    localparam int WL = 8;
    localparam int OS = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          uart_recH = 1'b1;
    logic          rec_readH = 1'b0;
    logic [WL-1:0] rec_dataH;
    logic          rec_validH;
    logic          frame_errH;
    logic          overrunH;
    logic          rec_busyH;

    int errors = 0;
    int checks = 0;

    logic [WL+1:0] exp_q[$];

    u_rec #(.WORD_LEN(WL), .OVERSAMPLE(OS)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .uart_recH (uart_recH),
        .rec_readH (rec_readH),
        .rec_dataH (rec_dataH),
        .rec_validH(rec_validH),
        .frame_errH(frame_errH),
        .overrunH  (overrunH),
        .rec_busyH (rec_busyH)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a new word is a rise of rec_validH or a reload while it stays HI.
    logic          prev_v = 1'b0;
    logic [WL-1:0] prev_d = '0;
    logic          prev_f = 1'b0;
    logic          prev_o = 1'b0;

    always @(negedge sys_clk) begin
        if (!sys_rst && rec_validH &&
            (!prev_v || rec_dataH != prev_d || frame_errH != prev_f || overrunH != prev_o)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got data=%0h ferr=%0b ovr=%0b expected none",
                         rec_dataH, frame_errH, overrunH);
            end else begin
                check("word{data,ferr,ovr}", {22'd0, rec_dataH, frame_errH, overrunH},
                      {22'd0, exp_q.pop_front()});
            end
        end
        prev_v = rec_validH;
        prev_d = rec_dataH;
        prev_f = frame_errH;
        prev_o = overrunH;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_frame(input logic [WL-1:0] d, input logic stop_bit);
        uart_recH = 1'b0;
        cycles(OS);
        for (int i = 0; i < WL; i++) begin
            uart_recH = d[i];
            cycles(OS);
        end
        uart_recH = stop_bit;
        cycles(OS);
    endtask

    task automatic do_read();
        rec_readH = 1'b1;
        cycles(1);
        rec_readH = 1'b0;
    endtask

    task automatic wait_valid(input int bound);
        int n;
        n = 0;
        while (!rec_validH && n < bound) begin
            cycles(1);
            n++;
        end
        check("wait_valid_timeout", {31'd0, rec_validH}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;

        // Reset state
        cycles(3);
        check("rst_data",  {24'd0, rec_dataH}, 32'h0);
        check("rst_valid", {31'd0, rec_validH}, 32'd0);
        check("rst_ferr",  {31'd0, frame_errH}, 32'd0);
        check("rst_ovr",   {31'd0, overrunH}, 32'd0);
        check("rst_busy",  {31'd0, rec_busyH}, 32'd0);
        sys_rst = 1'b0;
        cycles(5);

        // 0xA5, exact latency: valid LO after E0+153, HI after E0+154
        exp_q.push_back({8'hA5, 1'b0, 1'b0});
        fork
            send_frame(8'hA5, 1'b1);
            begin
                cycles(154);
                check("lat_before", {31'd0, rec_validH}, 32'd0);
                cycles(1);
                check("lat_at", {31'd0, rec_validH}, 32'd1);
            end
        join
        do_read();
        check("read_clears_valid", {31'd0, rec_validH}, 32'd0);
        cycles(10);

        // Back-to-back 0x00 / 0xFF, each read 20 clocks after valid
        exp_q.push_back({8'h00, 1'b0, 1'b0});
        exp_q.push_back({8'hFF, 1'b0, 1'b0});
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                wait_valid(400);
                cycles(20);
                do_read();
                wait_valid(400);
                cycles(20);
                do_read();
            end
        join
        cycles(10);

        // 4-clock LO glitch on idle line
        busy_cnt = 0;
        uart_recH = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 4) uart_recH = 1'b1;
            cycles(1);
            if (rec_busyH) busy_cnt++;
        end
        check("glitch_busy_range", {31'd0, (busy_cnt >= 8 && busy_cnt <= 11)}, 32'd1);
        check("glitch_busy_end", {31'd0, rec_busyH}, 32'd0);
        check("glitch_valid", {31'd0, rec_validH}, 32'd0);

        // 0x3C with LO stop, line held LO, then clean 0x12
        exp_q.push_back({8'h3C, 1'b1, 1'b0});
        send_frame(8'h3C, 1'b0);
        cycles(40);
        uart_recH = 1'b1;
        cycles(10);
        check("break_no_overrun", {31'd0, overrunH}, 32'd0);
        do_read();
        cycles(10);
        exp_q.push_back({8'h12, 1'b0, 1'b0});
        send_frame(8'h12, 1'b1);
        cycles(10);
        check("ferr_cleared", {31'd0, frame_errH}, 32'd0);
        do_read();
        cycles(10);

        // Overrun: 0x11 then 0x22 unread
        exp_q.push_back({8'h11, 1'b0, 1'b0});
        exp_q.push_back({8'h22, 1'b0, 1'b1});
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        cycles(5);
        do_read();
        check("ovr_read_valid", {31'd0, rec_validH}, 32'd0);
        check("ovr_read_ovr", {31'd0, overrunH}, 32'd0);
        cycles(10);

        // Read lands on the second completion edge (E0+314)
        exp_q.push_back({8'h11, 1'b0, 1'b0});
        exp_q.push_back({8'h22, 1'b0, 1'b0});
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                cycles(314);
                do_read();
            end
        join
        cycles(3);
        check("simul_valid", {31'd0, rec_validH}, 32'd1);
        check("simul_ovr", {31'd0, overrunH}, 32'd0);
        do_read();
        cycles(10);

        // Leave 0x12 unread, then reset during bit 4 of a frame
        exp_q.push_back({8'h12, 1'b0, 1'b0});
        send_frame(8'h12, 1'b1);
        cycles(5);
        uart_recH = 1'b0;
        cycles(OS);
        for (int i = 0; i < 4; i++) begin
            uart_recH = ~uart_recH;
            cycles(OS);
        end
        uart_recH = 1'b1;
        cycles(OS / 2);
        sys_rst = 1'b1;
        cycles(3);
        sys_rst = 1'b0;
        check("mid_rst_data",  {24'd0, rec_dataH}, 32'h0);
        check("mid_rst_valid", {31'd0, rec_validH}, 32'd0);
        check("mid_rst_ferr",  {31'd0, frame_errH}, 32'd0);
        check("mid_rst_ovr",   {31'd0, overrunH}, 32'd0);
        check("mid_rst_busy",  {31'd0, rec_busyH}, 32'd0);
        cycles(10);
        exp_q.push_back({8'h5A, 1'b0, 1'b0});
        send_frame(8'h5A, 1'b1);
        cycles(10);
        check("post_rst_data", {24'd0, rec_dataH}, 32'h5A);
        do_read();
        cycles(20);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
